rr_lock_arbiter: RTL

Round-robin arbiter with grant locking and a hold-time limit for sharing one resource among `N` requesters. It wraps the fixed-priority selection scheme with a rotating priority pointer, so every requester gets served fairly. A granted requester keeps exclusive ownership across multi-cycle transactions until it releases or its hold budget runs out. It sits between the requesting masters and the shared port and drives that port's select lines.

---
 rtl/rr_lock_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant locking and a per-grant hold limit.
// The owner keeps the resource until it drops its request or uses up MAX_HOLD cycles.
module rr_lock_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id
);

    localparam int          IW   = $clog2(N);
    localparam int          HW   = $clog2(MAX_HOLD + 1);
    localparam int unsigned NU   = N;
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [IW-1:0] id_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic [N-1:0]  grant_n;
    logic [N-1:0]  cand;
    logic          found;
    logic [IW-1:0] sel;
    int unsigned   j;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] k);
        return (k == IW'(N - 1)) ? '0 : k + 1'b1;
    endfunction

    // Clearing the owner bit is a no-op in IDLE (grant is zero there),
    // so the same candidate scan serves both initial grant and handoff.
    always_comb begin
        cand  = req & ~grant;
        found = 1'b0;
        sel   = '0;
        j     = 0;
        for (int unsigned i = 0; i < NU; i++) begin
            j = {{(32-IW){1'b0}}, ptr} + i;
            if (j >= NU) j = j - NU;
            if (!found && cand[j[IW-1:0]]) begin
                found = 1'b1;
                sel   = j[IW-1:0];
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hcnt_n  = hcnt;
        grant_n = grant;
        id_n    = grant_id;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n      = BUSY;
                    grant_n      = '0;
                    grant_n[sel] = 1'b1;
                    id_n         = sel;
                    hcnt_n       = HW'(1);
                    ptr_n        = next_ptr(sel);
                end
            end
            BUSY: begin
                if (req[grant_id] && hcnt < HMAX) begin
                    hcnt_n = hcnt + 1'b1;
                end else if (found) begin
                    grant_n      = '0;
                    grant_n[sel] = 1'b1;
                    id_n         = sel;
                    hcnt_n       = HW'(1);
                    ptr_n        = next_ptr(sel);
                end else if (req[grant_id]) begin
                    hcnt_n = HW'(1);
                end else begin
                    state_n = IDLE;
                    grant_n = '0;
                    id_n    = '0;
                    hcnt_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                id_n    = '0;
                hcnt_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hcnt        <= '0;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            hcnt        <= hcnt_n;
            grant       <= grant_n;
            grant_id    <= id_n;
            grant_valid <= |grant_n;
        end
    end

endmodule
